// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RISC-V subset datapath (R-type, ld, sd, beq).
// Sequences fetch/decode/execute/mem/writeback and stalls memory states on mem_ready.
module multicycle_main_control #(
    parameter logic [6:0] OP_RTYPE = 7'b0110011,
    parameter logic [6:0] OP_LD    = 7'b0000011,
    parameter logic [6:0] OP_SD    = 7'b0100011,
    parameter logic [6:0] OP_BEQ   = 7'b1100011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic [1:0] ALUop,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_READ = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WRITE= 4'd6,
        S_EXEC     = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 1'b0;
        ALUop         = 2'b00;
        illegal_instr = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                // PC+4 and IR load happen only on the cycle the read completes
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b10;
                if (opcode == OP_RTYPE)                      state_d = S_EXEC;
                else if (opcode == OP_LD || opcode == OP_SD) state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
                else begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // opcode is resampled here; anything but ld/sd abandons the access
                if (opcode == OP_LD)      state_d = S_MEM_READ;
                else if (opcode == OP_SD) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed instruction walk with literal checks,
// then random opcodes/mem_ready/reset checked every cycle against a step-based model.
module tb_multicycle_main_control;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SD  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] ILL = 7'b0010011;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa;
        logic [1:0] asb;
        logic pcs;
        logic [1:0] aop;
        logic ill;
    } ov_t;

    localparam int K_R = 0, K_MEM = 1, K_LD = 2, K_SD = 3, K_BEQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite;
    logic ALUSrcA, PCSource, illegal_instr;
    logic [1:0] ALUSrcB, ALUop;

    int errors = 0;
    int checks = 0;
    int step = 0;   // 0 reset, 1 fetch, 2 decode, 3..5 execution steps of the instruction
    int kind = K_R;
    int cyc = 0;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUop(ALUop),
        .illegal_instr(illegal_instr)
    );

    function automatic ov_t actual();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, ALUop, illegal_instr};
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op == R || op == LD || op == SD || op == BEQ;
    endfunction

    // What the outputs must be at a given step of an instruction
    function automatic ov_t expect_out(input int k, input int s, input logic mr, input logic [6:0] op);
        ov_t o = '0;
        case (s)
            1: begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
            2: begin o.asb = 2'b10; o.ill = !legal(op); end
            3: begin
                o.asa = 1;
                if (k == K_R)        o.aop = 2'b10;
                else if (k == K_MEM) o.asb = 2'b10;
                else begin o.aop = 2'b01; o.pcwc = 1; o.pcs = 1; end
            end
            4: begin
                if (k == K_R)       o.rw = 1;
                else if (k == K_LD) begin o.mrd = 1; o.iord = 1; end
                else                begin o.mwr = 1; o.iord = 1; end
            end
            5: begin o.rw = 1; o.m2r = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic advance_model();
        if (!rst_n) begin step = 0; return; end
        case (step)
            0: step = 1;
            1: if (mem_ready) step = 2;
            2: begin
                if (opcode == R)                      begin kind = K_R;   step = 3; end
                else if (opcode == LD || opcode == SD) begin kind = K_MEM; step = 3; end
                else if (opcode == BEQ)               begin kind = K_BEQ; step = 3; end
                else step = 1;
            end
            3: begin
                if (kind == K_MEM) begin
                    if (opcode == LD)      begin kind = K_LD; step = 4; end
                    else if (opcode == SD) begin kind = K_SD; step = 4; end
                    else step = 1;
                end else if (kind == K_R) step = 4;
                else step = 1;
            end
            4: begin
                if (kind == K_R)       step = 1;
                else if (kind == K_LD) step = mem_ready ? 5 : 4;
                else                   step = mem_ready ? 1 : 4;
            end
            default: step = 1;
        endcase
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock: model follows the edge, new inputs applied, outputs compared to the model
    task automatic cycle(input logic rst, input logic [6:0] op, input logic mr);
        ov_t e;
        @(posedge clk);
        advance_model();
        cyc++;
        #1;
        rst_n = rst; opcode = op; mem_ready = mr;
        if (!rst_n) step = 0;
        #1;
        e = expect_out(kind, step, mem_ready, opcode);
        chk("model_outputs", 16'(actual()), 16'(e));
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = R; ops[1] = LD; ops[2] = SD; ops[3] = BEQ; ops[4] = ILL;

        // reset held 5 cycles
        for (int i = 0; i < 5; i++) cycle(1'b0, R, 1'b1);
        chk("reset_zero", 16'(actual()), 16'h0);
        cycle(1'b1, R, 1'b1);
        chk("post_reset_idle", 16'(actual()), 16'h0);
        // R-type, 4 cycles
        cycle(1'b1, R, 1'b1);
        chk("fetch_req", {13'd0, MemRead, IorD, PCWrite}, 16'b101);
        chk("fetch_srcb", 16'(ALUSrcB), 16'b01);
        cycle(1'b1, R, 1'b1);
        chk("decode_srcb", 16'(ALUSrcB), 16'b10);
        cycle(1'b1, R, 1'b1);
        chk("exec_aluop", 16'(ALUop), 16'b10);
        cycle(1'b1, R, 1'b1);
        chk("aluwb_regwrite", {14'd0, RegWrite, MemtoReg}, 16'b10);
        // ld with three stall cycles in MEM_READ
        cycle(1'b1, LD, 1'b1);
        chk("r_len4_back_to_fetch", 16'(MemRead), 16'd1);
        cycle(1'b1, LD, 1'b1);
        cycle(1'b1, LD, 1'b0);
        chk("memaddr_src", {14'd0, ALUSrcA, ALUSrcB[1]}, 16'b11);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, LD, (i == 3) ? 1'b1 : 1'b0);
            chk("memread_held", {14'd0, MemRead, IorD}, 16'b11);
        end
        cycle(1'b1, SD, 1'b1);
        chk("memwb", {14'd0, RegWrite, MemtoReg}, 16'b11);
        // sd then beq
        cycle(1'b1, SD, 1'b1);
        cycle(1'b1, SD, 1'b1);
        cycle(1'b1, SD, 1'b1);
        cycle(1'b1, SD, 1'b1);
        chk("memwrite", {13'd0, MemWrite, MemRead, RegWrite}, 16'b100);
        cycle(1'b1, BEQ, 1'b1);
        chk("sd_back_to_fetch", 16'(MemRead), 16'd1);
        cycle(1'b1, BEQ, 1'b1);
        cycle(1'b1, BEQ, 1'b1);
        chk("branch", {11'd0, ALUop, PCWriteCond, PCSource, ALUSrcA}, 16'b01111);
        // illegal opcode
        cycle(1'b1, ILL, 1'b1);
        chk("fetch_no_illegal", 16'(illegal_instr), 16'd0);
        cycle(1'b1, ILL, 1'b1);
        chk("illegal_pulse", {13'd0, illegal_instr, RegWrite, MemWrite}, 16'b100);
        cycle(1'b1, SD, 1'b1);
        chk("illegal_to_fetch", {14'd0, MemRead, illegal_instr}, 16'b10);
        // reset in the middle of a stalled store
        cycle(1'b1, SD, 1'b1);
        cycle(1'b1, SD, 1'b0);
        cycle(1'b1, SD, 1'b0);
        chk("store_stall", 16'(MemWrite), 16'd1);
        cycle(1'b0, SD, 1'b0);
        chk("reset_drops_memwrite", 16'(actual()), 16'h0);
        cycle(1'b1, SD, 1'b0);
        chk("restart_idle", 16'(actual()), 16'h0);
        cycle(1'b1, SD, 1'b1);
        chk("restart_fetch", 16'(MemRead), 16'd1);

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            logic r;
            r = ($urandom_range(0, 99) != 0);
            cycle(r, ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL rd_wr_exclusive cyc=%0d got both=1 expected not both", cyc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
